// File: rtl/divider_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// divider_pkg : shared defaults and width helper for the divider chain
// Rev 1.0
// ---------------------------------------------------------------------------
package divider_pkg;

  localparam int unsigned DEF_PRE_MOD = 2;
  localparam int unsigned DEF_CNT_W   = 3;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/modulo_divider_chain_mod_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_counter : modulo counter with sync clear/load and terminal-count flag
// Rev 1.0
// ---------------------------------------------------------------------------
module mod_counter
  import divider_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_term;

  // >= so a terminal lowered below the count wraps on the next enable.
  assign at_term = (cnt_q >= term_i);
  assign tc_o    = en_i && at_term && !clr_i && !load_i;
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = at_term ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/modulo_divider_chain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// modulo_divider_chain : prescaler cascaded into a modulo main counter
// Rev 1.0
// ---------------------------------------------------------------------------
module modulo_divider_chain
  import divider_pkg::*;
#(
  parameter  int unsigned PRE_MOD = DEF_PRE_MOD,
  parameter  int unsigned CNT_W   = DEF_CNT_W,
  localparam int unsigned PW      = width_of(PRE_MOD)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             ena,
  input  logic             enb,
  input  logic             cascade,
  input  logic [CNT_W-1:0] mod_m1,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [PW-1:0]    pre_q,
  output logic [CNT_W-1:0] cnt_q,
  output logic             pre_tc,
  output logic             cnt_tc,
  output logic             wrap,
  output logic             out_sq
);

  localparam logic [PW-1:0] PRE_TERM = PW'(PRE_MOD - 1);

  logic             tick;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   half;
  logic             wrap_q;
  logic             wrap_d;
  logic             out_sq_q;
  logic             out_sq_d;

  mod_counter #(
    .W (PW)
  ) u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (clr),
    .load_i     (1'b0),
    .load_val_i ({PW{1'b0}}),
    .en_i       (ena),
    .term_i     (PRE_TERM),
    .cnt_o      (pre_q),
    .tc_o       (pre_tc)
  );

  assign tick = cascade ? pre_tc : enb;

  mod_counter #(
    .W (CNT_W)
  ) u_main (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (clr),
    .load_i     (load),
    .load_val_i (load_val),
    .en_i       (tick),
    .term_i     (mod_m1),
    .cnt_o      (cnt_q),
    .tc_o       (cnt_tc)
  );

  // Square output tracks the value the main counter is about to take.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (tick) begin
      cnt_d = cnt_tc ? '0 : cnt_q + 1'b1;
    end
  end

  assign half     = ({1'b0, mod_m1} + 1'b1) >> 1;
  assign out_sq_d = !clr && ({1'b0, cnt_d} >= half);
  assign wrap_d   = !clr && cnt_tc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q   <= 1'b0;
      out_sq_q <= 1'b0;
    end else begin
      wrap_q   <= wrap_d;
      out_sq_q <= out_sq_d;
    end
  end

  assign wrap   = wrap_q;
  assign out_sq = out_sq_q;

endmodule
`default_nettype wire
